// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the control sequencer -- opcodes, ALU
// codes, instruction field positions, FSM state encoding and decode record.
package ctrl_pkg;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_ALU  = 6'h00;
    localparam logic [5:0] OP_LD   = 6'h01;
    localparam logic [5:0] OP_ST   = 6'h02;
    localparam logic [5:0] OP_BZ   = 6'h03;
    localparam logic [5:0] OP_BR   = 6'h04;
    localparam logic [5:0] OP_HALT = 6'h3F;

    // ALU operation used for load/store address generation
    localparam logic [4:0] ALU_ADD = 5'd0;

    // Instruction field bit positions
    localparam int OP_MSB   = 31;
    localparam int OP_LSB   = 26;
    localparam int RS_MSB   = 25;
    localparam int RS_LSB   = 21;
    localparam int RT_MSB   = 20;
    localparam int RT_LSB   = 16;
    localparam int IMM_MSB  = 15;
    localparam int IMM_LSB  = 0;
    localparam int FUNC_MSB = 4;
    localparam int FUNC_LSB = 0;

    // ALU flag bit that resolves BZ
    localparam int FLAG_ZERO = 0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT,
        ST_TRAP
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LD,
        CLS_ST,
        CLS_BZ,
        CLS_BR,
        CLS_HALT,
        CLS_ILLEGAL
    } op_class_t;

    // Everything the FSM needs to know about the instruction in IR
    typedef struct packed {
        op_class_t   cls;
        logic [4:0]  alu_op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [15:0] imm;
        logic        is_branch;
        logic        is_mem;
        logic        is_wb;
    } decode_t;

endpackage

// File: rtl/ctrl_sequencer_if.sv
// ctrl_sequencer_if: instruction-memory port plus datapath control/flag
// signals between the sequencer (master) and the memory/datapath (slave).
interface ctrl_sequencer_if #(
    parameter int PC_W = 32
);
    logic [PC_W-1:0] imem_addr;
    logic            imem_req;
    logic [31:0]     imem_rdata;
    logic [2:0]      flags;
    logic [4:0]      r1;
    logic [4:0]      r2;
    logic [4:0]      alu_ctrl;
    logic            regw;
    logic            memr;
    logic            memw;

    modport master (
        output imem_addr, imem_req, r1, r2, alu_ctrl, regw, memr, memw,
        input  imem_rdata, flags
    );

    modport slave (
        input  imem_addr, imem_req, r1, r2, alu_ctrl, regw, memr, memw,
        output imem_rdata, flags
    );
endinterface

// File: rtl/ctrl_decode.sv
// ctrl_decode: purely combinational instruction decoder, IR -> decode record.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [31:0] ir,
    output decode_t     dec
);

    // Classify the opcode and derive ALU op and sequencing flags
    always_comb begin
        // NOTE: every field gets a default before the case so no path leaves
        // a field unassigned (which would infer a latch).
        dec.cls       = CLS_ILLEGAL;
        dec.alu_op    = ir[FUNC_MSB:FUNC_LSB];
        dec.rs        = ir[RS_MSB:RS_LSB];
        dec.rt        = ir[RT_MSB:RT_LSB];
        dec.imm       = ir[IMM_MSB:IMM_LSB];
        dec.is_branch = 1'b0;
        dec.is_mem    = 1'b0;
        dec.is_wb     = 1'b0;
        case (ir[OP_MSB:OP_LSB])
            OP_ALU: begin
                dec.cls   = CLS_ALU;
                dec.is_wb = 1'b1;
            end
            OP_LD: begin
                dec.cls    = CLS_LD;
                dec.alu_op = ALU_ADD;
                dec.is_mem = 1'b1;
                dec.is_wb  = 1'b1;
            end
            OP_ST: begin
                dec.cls    = CLS_ST;
                dec.alu_op = ALU_ADD;
                dec.is_mem = 1'b1;
            end
            OP_BZ: begin
                dec.cls       = CLS_BZ;
                dec.is_branch = 1'b1;
            end
            OP_BR: begin
                dec.cls       = CLS_BR;
                dec.is_branch = 1'b1;
            end
            OP_HALT: dec.cls = CLS_HALT;
            default: dec.cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: multi-cycle fetch/decode/execute control stage with PC and
// retired-instruction counter.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN -- when defined, an illegal
// opcode parks the sequencer in a sticky trap; otherwise it retires as a NOP
// and trap is tied low.
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [PC_W-1:0] PC_INC   = PC_W'(1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    ctrl_sequencer_if.master bus,
    output logic [PC_W-1:0]  pc,
    output logic [31:0]      instr_cnt,
    output logic             halted,
    output logic             trap
);

    state_t          state_q;
    state_t          state_d;
    logic [31:0]     ir_q;
    logic [PC_W-1:0] pc_q;
    logic [31:0]     cnt_q;
    logic [4:0]      r1_q;
    logic [4:0]      r2_q;
    logic [4:0]      alu_q;
    decode_t         dec;
    logic            retire;
    logic            take_branch;
    logic            req;
    logic            regw;
    logic            memr;
    logic            memw;
    logic [PC_W-1:0] pc_seq;
    logic [PC_W-1:0] pc_next;
    logic            unused_flags;

    ctrl_decode u_decode (
        .ir  (ir_q),
        .dec (dec)
    );

    // Sequential PC and branch target (sign-extended 16-bit offset, wraps)
    assign pc_seq  = pc_q + PC_INC;
    assign pc_next = take_branch ? pc_seq + {{(PC_W-16){dec.imm[15]}}, dec.imm} : pc_seq;

    // Next-state and strobe generation
    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        take_branch = 1'b0;
        req         = 1'b0;
        regw        = 1'b0;
        memr        = 1'b0;
        memw        = 1'b0;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_FETCH;
            ST_FETCH: begin
                req     = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT:   state_d = ST_DECODE;
            ST_DECODE: begin
                if (dec.cls == CLS_HALT) begin
                    retire  = 1'b1;
                    state_d = ST_HALT;
                end
`ifdef CTRL_ILLEGAL_TRAP_EN
                else if (dec.cls == CLS_ILLEGAL) begin
                    state_d = ST_TRAP;
                end
`endif
                else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (dec.is_mem) begin
                    state_d = ST_MEM;
                end else if (dec.is_wb) begin
                    state_d = ST_WB;
                end else begin
                    // Branches and illegal-as-NOP retire here; BZ uses this cycle's flags
                    retire      = 1'b1;
                    take_branch = dec.is_branch &&
                                  ((dec.cls == CLS_BR) || bus.flags[FLAG_ZERO]);
                    state_d     = ST_FETCH;
                end
            end
            ST_MEM: begin
                if (dec.is_wb) begin
                    memr    = 1'b1;
                    state_d = ST_WB;
                end else begin
                    memw    = 1'b1;
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_WB: begin
                regw    = 1'b1;
                retire  = 1'b1;
                state_d = ST_FETCH;
            end
            ST_HALT:   state_d = ST_HALT;
            ST_TRAP:   state_d = ST_TRAP;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // IR capture, decoded register operands, PC and retire counter
    always_ff @(posedge clk) begin
        if (reset) begin
            ir_q  <= '0;
            pc_q  <= RESET_PC;
            cnt_q <= '0;
            r1_q  <= '0;
            r2_q  <= '0;
            alu_q <= '0;
        end else begin
            if (state_q == ST_WAIT) ir_q <= bus.imem_rdata;
            if (state_q == ST_DECODE) begin
                r1_q  <= dec.rs;
                r2_q  <= dec.rt;
                alu_q <= dec.alu_op;
            end
            if (retire) begin
                pc_q  <= pc_next;
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

    // Strobes are suppressed while reset is asserted so an aborted instruction
    // never reaches the datapath or memory.
    assign bus.imem_req  = req  & ~reset;
    assign bus.regw      = regw & ~reset;
    assign bus.memr      = memr & ~reset;
    assign bus.memw      = memw & ~reset;
    assign bus.imem_addr = pc_q;
    assign bus.r1        = r1_q;
    assign bus.r2        = r2_q;
    assign bus.alu_ctrl  = alu_q;

    assign pc        = pc_q;
    assign instr_cnt = cnt_q;
    assign halted    = (state_q == ST_HALT);
`ifdef CTRL_ILLEGAL_TRAP_EN
    assign trap      = (state_q == ST_TRAP);
`else
    assign trap      = 1'b0;
`endif

    // Only the zero flag resolves branches
    assign unused_flags = ^bus.flags[2:1];

endmodule
